// File: rtl/riscv_if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Defines the fetch sequencer states and the PC increment and alignment constants.
package riscv_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] PC_INCR              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0;
    localparam logic [31:0] PC_ALIGN_MASK        = ~32'h3;

    // A redirect target that is not word aligned cannot be fetched as-is.
    function automatic logic pc_misaligned(input logic [31:0] target);
        return (target[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer for the RV32I core.
// The next sequential PC comes from the external adder (add_a = pc, add_b = 4).
module pc_fetch_unit
    import riscv_if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,

    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,

    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,

    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misaligned
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         kill;

    always_comb begin
        add_a          = pc;
        add_b          = PC_INCR;
        imem_req_valid = (state == REQ);
        imem_req_addr  = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            kill       <= 1'b0;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0;
            if_instr   <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            if (redirect_valid && pc_misaligned(redirect_pc)) begin
                misaligned <= 1'b1;
            end

            if (redirect_valid) begin
                // Redirect wins over every other event; an in-flight request is
                // marked so its response is thrown away when it returns.
                pc       <= redirect_pc & PC_ALIGN_MASK;
                if_valid <= 1'b0;
                case (state)
                    IDLE, HOLD: begin
                        state <= REQ;
                    end
                    REQ: begin
                        if (imem_req_ready) begin
                            req_pc <= pc;
                            kill   <= 1'b1;
                            state  <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        state <= REQ;
                    end
                    REQ: begin
                        if (imem_req_ready) begin
                            req_pc <= pc;
                            pc     <= add_sum;
                            state  <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            if (kill) begin
                                kill  <= 1'b0;
                                state <= REQ;
                            end else begin
                                if_pc    <= req_pc;
                                if_instr <= imem_rsp_data;
                                if_valid <= 1'b1;
                                state    <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (if_valid && !stall) begin
                            if_valid <= 1'b0;
                            state    <= REQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
